// File: rtl/ex_div.sv
// Iterative RV64M divide/remainder unit for the EX stage: one restoring step per
// cycle, divide-by-zero and signed overflow resolved without iterating.
module ex_div #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_start_i,
  input  logic [1:0]            div_op_i,
  input  logic                  word_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic [4:0]            addr_rd_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  stall_req_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  result_valid_o,
  output logic [4:0]            addr_rd_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [6:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic                  word_q, word_d;
  logic                  is_rem_q, is_rem_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [4:0]            rd_q, rd_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  valid_q, valid_d;
  logic [4:0]            addr_q, addr_d;

  // Operand preparation from the ID/EX register
  logic                  signed_op, rem_op;
  logic [DATA_WIDTH-1:0] a_ext, b_ext, a_sext32, a_mag, b_mag;
  logic                  a_neg, b_neg, div_zero, overflow;
  logic [DATA_WIDTH-1:0] special_res;

  always_comb begin
    signed_op = ~div_op_i[0];
    rem_op    = div_op_i[1];
    a_sext32  = {{32{dividend_i[31]}}, dividend_i[31:0]};
    if (word_i) begin
      a_ext = signed_op ? a_sext32 : {32'b0, dividend_i[31:0]};
      b_ext = signed_op ? {{32{divisor_i[31]}}, divisor_i[31:0]} : {32'b0, divisor_i[31:0]};
    end else begin
      a_ext = dividend_i;
      b_ext = divisor_i;
    end
    a_neg    = signed_op & a_ext[63];
    b_neg    = signed_op & b_ext[63];
    a_mag    = a_neg ? (~a_ext + 64'd1) : a_ext;
    b_mag    = b_neg ? (~b_ext + 64'd1) : b_ext;
    div_zero = (b_ext == 64'd0);
    overflow = signed_op && (b_ext == {64{1'b1}}) &&
               (word_i ? (a_ext == 64'hFFFF_FFFF_8000_0000) : (a_ext == 64'h8000_0000_0000_0000));
    if (div_zero)
      special_res = rem_op ? (word_i ? a_sext32 : dividend_i) : {64{1'b1}};
    else
      special_res = rem_op ? 64'd0 : (word_i ? a_sext32 : dividend_i);
  end

  // One restoring step; the borrow bit of the 65-bit trial subtract decides the quotient bit
  logic [DATA_WIDTH:0]   rem_sh, diff;
  logic                  fits;
  logic [DATA_WIDTH-1:0] rem_nx, quo_nx, sel_mag, fix64;
  logic [31:0]           fix32;
  logic                  neg_sel;
  logic [DATA_WIDTH-1:0] final_res;

  always_comb begin
    rem_sh    = {rem_q, quo_q[63]};
    diff      = rem_sh - {1'b0, dvs_q};
    fits      = ~diff[64];
    rem_nx    = fits ? diff[63:0] : rem_sh[63:0];
    quo_nx    = {quo_q[62:0], fits};
    sel_mag   = is_rem_q ? rem_nx : quo_nx;
    neg_sel   = is_rem_q ? neg_rem_q : neg_quo_q;
    fix64     = neg_sel ? (~sel_mag + 64'd1) : sel_mag;
    fix32     = neg_sel ? (~sel_mag[31:0] + 32'd1) : sel_mag[31:0];
    final_res = word_q ? {{32{fix32[31]}}, fix32} : fix64;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    word_d    = word_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rd_d      = rd_q;
    result_d  = result_q;
    addr_d    = addr_q;
    valid_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (div_start_i) begin
          rd_d = addr_rd_i;
          if (div_zero || overflow) begin
            state_d  = S_DONE;
            result_d = special_res;
            addr_d   = addr_rd_i;
            valid_d  = 1'b1;
          end else begin
            state_d   = S_CALC;
            cnt_d     = word_i ? 7'd32 : 7'd64;
            rem_d     = 64'd0;
            // W operands sit in the upper half so 32 shifts walk every dividend bit
            quo_d     = word_i ? {a_mag[31:0], 32'b0} : a_mag;
            dvs_d     = b_mag;
            word_d    = word_i;
            is_rem_d  = rem_op;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end
      S_CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          state_d  = S_DONE;
          result_d = final_res;
          addr_d   = rd_q;
          valid_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A killed instruction leaves the visible outputs untouched
    if (flush_i) begin
      state_d  = S_IDLE;
      cnt_d    = 7'd0;
      result_d = result_q;
      addr_d   = addr_q;
      rd_d     = rd_q;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 7'd0;
      rem_q     <= 64'd0;
      quo_q     <= 64'd0;
      dvs_q     <= 64'd0;
      word_q    <= 1'b0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rd_q      <= 5'd0;
      result_q  <= 64'd0;
      valid_q   <= 1'b0;
      addr_q    <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      word_q    <= word_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign stall_req_o    = ((state_q == S_IDLE) && div_start_i && !flush_i) || (state_q == S_CALC);
  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign addr_rd_o      = addr_q;

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: directed vectors push expected results, a monitor
// pops and compares on every result_valid_o pulse.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start_i;
  logic [1:0]  div_op_i;
  logic        word_i;
  logic [63:0] dividend_i;
  logic [63:0] divisor_i;
  logic [4:0]  addr_rd_i;
  logic        flush_i;
  logic        busy_o;
  logic        stall_req_o;
  logic [63:0] result_o;
  logic        result_valid_o;
  logic [4:0]  addr_rd_o;

  always #5 clk = ~clk;

  ex_div #(.DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .div_start_i(div_start_i), .div_op_i(div_op_i),
    .word_i(word_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
    .addr_rd_i(addr_rd_i), .flush_i(flush_i), .busy_o(busy_o),
    .stall_req_o(stall_req_o), .result_o(result_o),
    .result_valid_o(result_valid_o), .addr_rd_o(addr_rd_o)
  );

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   pulses = 0;
  int   issued = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h required 0x%016h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && result_valid_o) begin
      pulses++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got result 0x%016h rd=%0d required no result", result_o, addr_rd_o);
      end else begin
        mon_e = sb_q.pop_front();
        check64({mon_e.name, "_result"}, result_o, mon_e.res);
        check_int({mon_e.name, "_rd"}, int'(addr_rd_o), int'(mon_e.rd));
        $display("txn %s rd=%0d result=0x%016h", mon_e.name, addr_rd_o, result_o);
      end
    end
  end

  // Called at a falling edge; holds start through DONE, drops it in the following IDLE cycle.
  task automatic run_op(input string name, input logic [1:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp, input int exp_lat);
    exp_t e;
    int   lat, stalls;
    bit   got;
    e.res = exp;
    e.rd = rd;
    e.name = name;
    sb_q.push_back(e);
    issued++;
    div_op_i = op; word_i = w; dividend_i = a; divisor_i = b; addr_rd_i = rd;
    div_start_i = 1'b1;
    lat = 0; stalls = 0; got = 1'b0;
    while (!got && lat < 100) begin
      #1;
      if (stall_req_o) stalls++;
      @(negedge clk);
      lat++;
      if (result_valid_o) got = 1'b1;
    end
    check_int({name, "_latency"}, lat, exp_lat);
    check_int({name, "_stall_cycles"}, stalls, exp_lat);
    check_int({name, "_stall_in_done"}, int'(stall_req_o), 0);
    @(negedge clk);
    div_start_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; div_start_i = 1'b0; div_op_i = 2'b00; word_i = 1'b0;
    dividend_i = 64'd0; divisor_i = 64'd0; addr_rd_i = 5'd0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    check_int("reset_valid", int'(result_valid_o), 0);
    check_int("reset_busy", int'(busy_o), 0);
    check64("reset_result", result_o, 64'd0);
    check_int("reset_rd", int'(addr_rd_o), 0);
    rst = 1'b0;
    @(negedge clk);

    run_op("div_m20_3", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd5, 64'hFFFF_FFFF_FFFF_FFFA, 65);
    run_op("rem_m20_3", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("divu_7_0", OP_DIVU, 1'b0, 64'd7, 64'd0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu_7_0", OP_REMU, 1'b0, 64'd7, 64'd0, 5'd8, 64'd7, 1);
    run_op("div_ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 64'd0, 1);
    run_op("divw_ovf", OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd11, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("divuw_hi", OP_DIVU, 1'b1, 64'h0000_0001_FFFF_FFFE, 64'd1, 5'd12, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_op("remw_m7_2", OP_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("divw_100_m7", OP_DIV, 1'b1, 64'hDEAD_0000_0000_0064, 64'h0000_1234_FFFF_FFF9, 5'd14, 64'hFFFF_FFFF_FFFF_FFF2, 33);
    run_op("remu_100_7", OP_REMU, 1'b0, 64'd100, 64'd7, 5'd15, 64'd2, 65);

    // Flush at the tenth CALC cycle: no result, idle next cycle
    div_op_i = OP_DIV; word_i = 1'b0; dividend_i = 64'd1000; divisor_i = 64'd3; addr_rd_i = 5'd20;
    div_start_i = 1'b1;
    repeat (10) @(negedge clk);
    check_int("flush_busy_before", int'(busy_o), 1);
    flush_i = 1'b1; div_start_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    check_int("flush_busy", int'(busy_o), 0);
    check_int("flush_stall", int'(stall_req_o), 0);
    check_int("flush_valid", int'(result_valid_o), 0);
    run_op("divu_100_7", OP_DIVU, 1'b0, 64'd100, 64'd7, 5'd21, 64'd14, 65);

    // Reset in the middle of CALC clears every output
    div_op_i = OP_DIV; word_i = 1'b0; dividend_i = 64'd12345; divisor_i = 64'd7; addr_rd_i = 5'd22;
    div_start_i = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1; div_start_i = 1'b0;
    @(negedge clk);
    check64("rst_mid_result", result_o, 64'd0);
    check_int("rst_mid_valid", int'(result_valid_o), 0);
    check_int("rst_mid_rd", int'(addr_rd_o), 0);
    check_int("rst_mid_busy", int'(busy_o), 0);
    check_int("rst_mid_stall", int'(stall_req_o), 0);
    rst = 1'b0;
    @(negedge clk);
    run_op("divu_after_rst", OP_DIVU, 1'b0, 64'h10, 64'd4, 5'd23, 64'd4, 65);

    repeat (5) @(negedge clk);
    check_int("valid_pulses", pulses, issued);
    check_int("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
